// File: rtl/branch_counter_bank_pkg.sv
// Shared definitions for the 2-bit branch predictor counter bank.
// - Counter state encoding (strong/weak taken/not-taken).
// - Reset state of every counter.
// - Lookup/update address offset: entry k lives at address k + ADDR_OFFSET,
//   so the update router and this bank decode addresses the same way.
// - Helper function computing the saturating next counter state.
package branch_counter_bank_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_state_e;

    localparam logic [1:0] CTR_RESET   = WEAK_NT;
    localparam int         ADDR_OFFSET = 1;

    // Saturating step: taken moves toward STRONG_T, not-taken toward STRONG_NT.
    function automatic logic [1:0] ctr_step(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != STRONG_T) nxt = cur + 2'd1;
        end else begin
            if (cur != STRONG_NT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_counter_bank_sat_counter_2bit.sv
// One 2-bit saturating branch counter.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset (state -> CTR_RESET)
//   en_i       - update strobe
//   outcome_i  - resolved direction (1 = taken), used only when en_i = 1
//   state_o    - current counter value
module sat_counter_2bit
    import branch_counter_bank_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       outcome_i,
    output logic [1:0] state_o
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) state_d = ctr_step(state_q, outcome_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= CTR_RESET;
        else         state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/branch_counter_bank.sv
// Bank of 2-bit saturating branch counters with registered lookup and a
// saturating misprediction statistics counter.
// Ports:
//   CLOCK            - clock, rising edge
//   RESET_N          - asynchronous active-low reset
//   UPD_OUTCOME      - per-entry resolved outcome (bit k -> entry k)
//   UPD_ENABLE       - per-entry update strobe
//   RD_VALID         - lookup request
//   RD_ADDR          - lookup address; entry k at RD_ADDR == k + ADDR_OFFSET
//   PREDICTION       - predicted direction of looked-up entry (registered)
//   PRED_STATE       - raw counter of looked-up entry (registered)
//   PRED_VALID       - one-cycle pulse one cycle after an in-range request
//   MISPREDICT_COUNT - saturating count of updates disagreeing with the
//                      entry's pre-update prediction
module branch_counter_bank
    import branch_counter_bank_pkg::*;
#(
    parameter int N_ENTRIES  = 2,
    parameter int ADDR_WIDTH = 3,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic [N_ENTRIES-1:0]  UPD_OUTCOME,
    input  logic [N_ENTRIES-1:0]  UPD_ENABLE,
    input  logic                  RD_VALID,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic                  PREDICTION,
    output logic [1:0]            PRED_STATE,
    output logic                  PRED_VALID,
    output logic [STAT_WIDTH-1:0] MISPREDICT_COUNT
);

    logic [N_ENTRIES-1:0][1:0] ctr_state;

    for (genvar k = 0; k < N_ENTRIES; k++) begin : g_ctr
        sat_counter_2bit u_ctr (
            .clk_i     (CLOCK),
            .rst_ni    (RESET_N),
            .en_i      (UPD_ENABLE[k]),
            .outcome_i (UPD_OUTCOME[k]),
            .state_o   (ctr_state[k])
        );
    end

    // Lookup mux reads the counters before this edge's update lands, which
    // gives read-before-write for a same-cycle read/update of one entry.
    logic       hit;
    logic [1:0] sel_state;

    always_comb begin
        hit       = 1'b0;
        sel_state = 2'b00;
        for (int k = 0; k < N_ENTRIES; k++) begin
            if (RD_ADDR == ADDR_WIDTH'(k + ADDR_OFFSET)) begin
                hit       = 1'b1;
                sel_state = ctr_state[k];
            end
        end
    end

    logic       pred_valid_q, pred_valid_d;
    logic [1:0] pred_state_q, pred_state_d;

    // State is zeroed when the result is not valid so nothing stale leaks out.
    always_comb begin
        pred_valid_d = RD_VALID & hit;
        pred_state_d = pred_valid_d ? sel_state : 2'b00;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pred_valid_q <= 1'b0;
            pred_state_q <= 2'b00;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_state_q <= pred_state_d;
        end
    end

    // Misprediction statistics: compare outcome with pre-update direction bit.
    logic [STAT_WIDTH-1:0] stat_q, stat_d;
    logic [STAT_WIDTH:0]   mis_n;
    logic [STAT_WIDTH:0]   stat_sum;

    always_comb begin
        mis_n = '0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            if (UPD_ENABLE[k] && (UPD_OUTCOME[k] != ctr_state[k][1]))
                mis_n = mis_n + (STAT_WIDTH+1)'(1);
        end
        // One extra bit catches overflow; clamp to all-ones instead of wrapping.
        stat_sum = {1'b0, stat_q} + mis_n;
        stat_d   = stat_sum[STAT_WIDTH] ? '1 : stat_sum[STAT_WIDTH-1:0];
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) stat_q <= '0;
        else          stat_q <= stat_d;
    end

    assign PRED_VALID       = pred_valid_q;
    assign PRED_STATE       = pred_state_q;
    assign PREDICTION       = pred_state_q[1];
    assign MISPREDICT_COUNT = stat_q;

endmodule

// File: tb/tb_branch_counter_bank.sv
module tb_branch_counter_bank;

    localparam int N  = 2;
    localparam int AW = 3;
    localparam int SW = 16;

    logic          CLOCK = 1'b0;
    logic          RESET_N = 1'b0;
    logic [N-1:0]  UPD_OUTCOME = '0;
    logic [N-1:0]  UPD_ENABLE = '0;
    logic          RD_VALID = 1'b0;
    logic [AW-1:0] RD_ADDR = '0;
    logic          PREDICTION;
    logic [1:0]    PRED_STATE;
    logic          PRED_VALID;
    logic [SW-1:0] MISPREDICT_COUNT;

    branch_counter_bank #(.N_ENTRIES(N), .ADDR_WIDTH(AW), .STAT_WIDTH(SW)) dut (
        .CLOCK            (CLOCK),
        .RESET_N          (RESET_N),
        .UPD_OUTCOME      (UPD_OUTCOME),
        .UPD_ENABLE       (UPD_ENABLE),
        .RD_VALID         (RD_VALID),
        .RD_ADDR          (RD_ADDR),
        .PREDICTION       (PREDICTION),
        .PRED_STATE       (PRED_STATE),
        .PRED_VALID       (PRED_VALID),
        .MISPREDICT_COUNT (MISPREDICT_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: integer counters 0..3, integer statistics.
    int m_ctr [N];
    int m_mis;
    int m_valid;
    int m_state;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_ctr[k] = 1;
        m_mis   = 0;
        m_valid = 0;
        m_state = 0;
    endtask

    task automatic do_reset();
        RESET_N     = 1'b0;
        UPD_ENABLE  = '0;
        UPD_OUTCOME = '0;
        RD_VALID    = 1'b0;
        RD_ADDR     = '0;
        model_reset();
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    // Called at a negedge; applies one cycle and returns at the next negedge.
    task automatic step(input logic [N-1:0] en, input logic [N-1:0] oc,
                        input logic rv, input logic [AW-1:0] addr);
        int a;
        UPD_ENABLE  = en;
        UPD_OUTCOME = oc;
        RD_VALID    = rv;
        RD_ADDR     = addr;
        @(posedge CLOCK);
        a       = int'(addr);
        m_valid = (rv && a >= 1 && a <= N) ? 1 : 0;
        m_state = m_valid ? m_ctr[a-1] : 0;
        for (int k = 0; k < N; k++) begin
            if (en[k]) begin
                if (int'(oc[k]) != (m_ctr[k] >= 2 ? 1 : 0))
                    m_mis = (m_mis >= 65535) ? 65535 : m_mis + 1;
                m_ctr[k] = oc[k] ? ((m_ctr[k] < 3) ? m_ctr[k] + 1 : 3)
                                 : ((m_ctr[k] > 0) ? m_ctr[k] - 1 : 0);
            end
        end
        @(negedge CLOCK);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " valid"}, int'(PRED_VALID), m_valid);
        chk({tag, " state"}, int'(PRED_STATE), m_state);
        chk({tag, " pred"},  int'(PREDICTION), m_state >= 2 ? 1 : 0);
        chk({tag, " mis"},   int'(MISPREDICT_COUNT), m_mis);
    endtask

    typedef struct {
        logic [N-1:0]  en;
        logic [N-1:0]  oc;
        logic          rv;
        logic [AW-1:0] addr;
        int            e_valid;
        int            e_state;
        int            e_mis;
    } vec_t;

    vec_t vecs [14];

    initial begin
        // Directed table from reset, expectations computed by hand.
        vecs[0]  = '{2'b00, 2'b00, 1'b1, 3'd1, 1, 1, 0};
        vecs[1]  = '{2'b01, 2'b01, 1'b0, 3'd0, 0, 0, 1};
        vecs[2]  = '{2'b01, 2'b01, 1'b0, 3'd0, 0, 0, 1};
        vecs[3]  = '{2'b01, 2'b01, 1'b0, 3'd0, 0, 0, 1};
        vecs[4]  = '{2'b01, 2'b01, 1'b0, 3'd0, 0, 0, 1};
        vecs[5]  = '{2'b00, 2'b00, 1'b1, 3'd1, 1, 3, 1};
        vecs[6]  = '{2'b00, 2'b11, 1'b1, 3'd0, 0, 0, 1};
        vecs[7]  = '{2'b00, 2'b11, 1'b1, 3'd7, 0, 0, 1};
        vecs[8]  = '{2'b00, 2'b00, 1'b1, 3'd2, 1, 1, 1};
        vecs[9]  = '{2'b10, 2'b10, 1'b1, 3'd2, 1, 1, 2};
        vecs[10] = '{2'b00, 2'b00, 1'b1, 3'd2, 1, 2, 2};
        vecs[11] = '{2'b11, 2'b00, 1'b1, 3'd1, 1, 3, 4};
        vecs[12] = '{2'b00, 2'b00, 1'b1, 3'd1, 1, 2, 4};
        vecs[13] = '{2'b00, 2'b00, 1'b1, 3'd2, 1, 1, 4};

        do_reset();
        chk("reset valid", int'(PRED_VALID), 0);
        chk("reset state", int'(PRED_STATE), 0);
        chk("reset pred",  int'(PREDICTION), 0);
        chk("reset mis",   int'(MISPREDICT_COUNT), 0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].en, vecs[i].oc, vecs[i].rv, vecs[i].addr);
            chk($sformatf("vec%0d valid", i), int'(PRED_VALID), vecs[i].e_valid);
            chk($sformatf("vec%0d state", i), int'(PRED_STATE), vecs[i].e_state);
            chk($sformatf("vec%0d pred", i),  int'(PREDICTION), vecs[i].e_state >= 2 ? 1 : 0);
            chk($sformatf("vec%0d mis", i),   int'(MISPREDICT_COUNT), vecs[i].e_mis);
        end

        // PRED_VALID is a single pulse: idle cycle after a lookup.
        step(2'b00, 2'b00, 1'b0, 3'd1);
        chk("pulse drop", int'(PRED_VALID), 0);

        // Both entries updated in one edge from reset.
        do_reset();
        step(2'b11, 2'b11, 1'b0, 3'd0);
        chk("dual mis", int'(MISPREDICT_COUNT), 2);
        step(2'b00, 2'b00, 1'b1, 3'd1);
        chk("dual e0", int'(PRED_STATE), 2);
        step(2'b00, 2'b00, 1'b1, 3'd2);
        chk("dual e1", int'(PRED_STATE), 2);
        chk("dual e1 pred", int'(PREDICTION), 1);

        // Build counters = 11/11 with five mispredictions, then async reset.
        do_reset();
        step(2'b01, 2'b01, 1'b0, 3'd0);
        step(2'b01, 2'b00, 1'b0, 3'd0);
        step(2'b01, 2'b01, 1'b0, 3'd0);
        step(2'b01, 2'b01, 1'b0, 3'd0);
        step(2'b10, 2'b10, 1'b0, 3'd0);
        step(2'b10, 2'b10, 1'b0, 3'd0);
        step(2'b01, 2'b00, 1'b0, 3'd0);
        step(2'b01, 2'b01, 1'b1, 3'd1);
        chk("pre-rst mis", int'(MISPREDICT_COUNT), 5);
        step(2'b00, 2'b00, 1'b1, 3'd2);
        chk("pre-rst e1", int'(PRED_STATE), 3);
        chk("pre-rst valid", int'(PRED_VALID), 1);
        UPD_ENABLE  = 2'b11;
        UPD_OUTCOME = 2'b11;
        RD_VALID    = 1'b1;
        RD_ADDR     = 3'd1;
        #2 RESET_N = 1'b0;
        #1;
        chk("async valid", int'(PRED_VALID), 0);
        chk("async state", int'(PRED_STATE), 0);
        chk("async pred",  int'(PREDICTION), 0);
        chk("async mis",   int'(MISPREDICT_COUNT), 0);
        model_reset();
        @(negedge CLOCK);
        RESET_N = 1'b1;
        step(2'b00, 2'b00, 1'b1, 3'd1);
        chk("post-rst e0", int'(PRED_STATE), 1);
        step(2'b00, 2'b00, 1'b1, 3'd2);
        chk("post-rst e1", int'(PRED_STATE), 1);
        chk("post-rst mis", int'(MISPREDICT_COUNT), 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom), N'($urandom), 1'($urandom), AW'($urandom_range(0, 7)));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_counter_bank.md
Name: branch_counter_bank

Overview:
- Update-side consumer and read-side provider for the 2-bit branch predictor.
- Holds one 2-bit saturating counter per predictor entry.
- Each counter is trained by the per-entry outcome/enable pairs produced by the update router.
- Answers prediction lookups by address with a registered, one-cycle-latency result, and keeps a saturating misprediction counter for performance monitoring.

Parameters:
- N_ENTRIES, 2, number of predictor entries (counters).
- ADDR_WIDTH, 3, width of the lookup address.
- STAT_WIDTH, 16, width of the misprediction statistics counter.

Ports:
- CLOCK  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- UPD_OUTCOME  input  N_ENTRIES  per-entry resolved branch outcome (1 = taken); bit k belongs to entry k.
- UPD_ENABLE  input  N_ENTRIES  per-entry update strobe; bit k qualifies UPD_OUTCOME[k].
- RD_VALID  input  1  lookup request, this cycle.
- RD_ADDR  input  ADDR_WIDTH  lookup address; entry k is selected when RD_ADDR == k+1 (same encoding as the update router).
- PREDICTION  output  1  predicted direction (1 = taken).
- PRED_STATE  output  2  raw counter value of the looked-up entry.
- PRED_VALID  output  1  PREDICTION/PRED_STATE valid this cycle.
- MISPREDICT_COUNT  output  STAT_WIDTH  number of updates whose outcome disagreed with the entry's pre-update prediction.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - every counter = 2'b01 (weakly not-taken);
  - PREDICTION = 0, PRED_STATE = 2'b00, PRED_VALID = 0, MISPREDICT_COUNT = 0.
- Reset asserted mid-operation discards any in-flight lookup and pending update immediately.
- Counter encoding:
  - 00 = strong NT, 01 = weak NT, 10 = weak T, 11 = strong T;
  - predicted direction = counter[1].
- Update, per entry k, at the rising edge with UPD_ENABLE[k] = 1:
  - outcome 1 → increment, saturating at 11;
  - outcome 0 → decrement, saturating at 00.
- UPD_OUTCOME[k] is ignored when UPD_ENABLE[k] = 0.
- Multiple enable bits in the same cycle update their entries independently and in parallel.
- Misprediction accounting:
  - for each enabled entry, mismatch = (UPD_OUTCOME[k] != counter_k[1]), using the pre-update value;
  - MISPREDICT_COUNT adds the number of mismatches this cycle (0..N_ENTRIES);
  - the counter saturates at all-ones and never wraps.
- Lookup:
  - RD_VALID sampled at edge t; outputs valid in the cycle after edge t (latency 1);
  - PRED_VALID is a single-cycle pulse per request;
  - back-to-back requests give back-to-back results;
  - no backpressure.
- Out-of-range address (RD_ADDR == 0 or > N_ENTRIES):
  - PRED_VALID = 0, PREDICTION = 0, PRED_STATE = 2'b00;
  - no state change.
- Read and update to the same entry in the same cycle: read-before-write. The lookup returns the pre-update counter value, and the new value is visible to lookups from the next cycle.
- When PRED_VALID = 0, PREDICTION and PRED_STATE are driven to 0 (no stale data).
- No combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - counter state constants (STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11);
  - the reset state (WEAK_NT);
  - the address-to-entry offset (1), so the update router and this block share one definition.
- One natural sub-module: sat_counter_2bit. It has one enable, one outcome and a 2-bit state output, and is instantiated N_ENTRIES times via generate.
- The lookup mux, output register and statistics counter stay in the top module.

Test Plan:
- Reset then RD_VALID = 1, RD_ADDR = 3'b001 → next cycle PRED_VALID = 1, PRED_STATE = 01, PREDICTION = 0; MISPREDICT_COUNT = 0.
- Four consecutive updates UPD_ENABLE = 01, UPD_OUTCOME = 01, then lookup ADDR = 001 → PRED_STATE = 11, PREDICTION = 1 (saturation held); MISPREDICT_COUNT = 1 (only the first update mismatched).
- Same cycle: UPD_ENABLE = 10, UPD_OUTCOME = 10, plus RD_VALID with ADDR = 010 on fresh reset → result PRED_STATE = 01 (old value); a lookup the next cycle returns 10, PREDICTION = 1.
- UPD_ENABLE = 11 with UPD_OUTCOME = 11 from reset → both entries go to 10 in one edge; MISPREDICT_COUNT increases by 2.
- RD_ADDR = 3'b000 and 3'b111 with RD_VALID = 1 → PRED_VALID = 0, PREDICTION = 0, PRED_STATE = 00; counters unchanged.
- Drive RESET_N low asynchronously between edges while counters = 11 and MISPREDICT_COUNT = 5 → all outputs and counters immediately return to their reset values without a clock edge.
